// File: rtl/systolic_pkg.sv
// Shared sizing for the systolic array: default operand/accumulator widths
// and the matching typedefs used by the array-level modules.
package systolic_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ACC_W_DEF  = 32;

  typedef logic [DATA_W_DEF-1:0] operand_t;
  typedef logic [ACC_W_DEF-1:0]  acc_t;

endpackage : systolic_pkg

// File: rtl/systolic_pe_mac.sv
// Combinational multiplier for one PE; the 2*DATA_W product is widened to
// ACC_W with zero- or sign-extension depending on SIGNED.
module pe_mac
  import systolic_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter bit SIGNED = 1'b0
) (
  input  logic [DATA_W-1:0] w,
  input  logic [DATA_W-1:0] a,
  output logic [ACC_W-1:0]  product
);

  generate
    if (SIGNED) begin : g_signed
      logic signed [2*DATA_W-1:0] prod_s;
      // A size cast of a signed value sign-extends it into the accumulator width.
      assign prod_s  = $signed(w) * $signed(a);
      assign product = ACC_W'(prod_s);
    end else begin : g_unsigned
      logic [2*DATA_W-1:0] prod_u;
      assign prod_u  = w * a;
      assign product = ACC_W'(prod_u);
    end
  endgenerate

endmodule : pe_mac

// File: rtl/systolic_pe.sv
// Output-stationary MAC processing element: accumulates w*a on out during a
// fire burst and forwards w, a and fire one cycle later to its neighbours.
module systolic_pe
  import systolic_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter bit SIGNED = 1'b0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              fire,
  input  logic [DATA_W-1:0] w,
  input  logic [DATA_W-1:0] a,
  output logic              out_f,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_w,
  output logic [ACC_W-1:0]  out
);

  logic [ACC_W-1:0] product;

  pe_mac #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W),
    .SIGNED (SIGNED)
  ) u_mac (
    .w       (w),
    .a       (a),
    .product (product)
  );

  // out_f doubles as "fired last cycle": a fire with out_f low starts a new
  // burst and discards the previous result instead of adding to it.
  always_ff @(posedge clk) begin
    if (rstn) begin
      out   <= '0;
      out_f <= 1'b0;
      out_a <= '0;
      out_w <= '0;
    end else begin
      out_a <= a;
      out_w <= w;
      out_f <= fire;
      if (fire) begin
        if (out_f) out <= out + product;
        else       out <= product;
      end
    end
  end

endmodule : systolic_pe

// File: tb/tb_systolic_pe.sv
// Directed bench for systolic_pe: one unsigned and one signed instance
// checked against hand-computed accumulator values.
module tb_systolic_pe;

  logic        clk;
  logic        rst;
  logic        fire, s_fire;
  logic [7:0]  w, a, s_w, s_a;
  logic        out_f, s_out_f;
  logic [7:0]  out_a, out_w, s_out_a, s_out_w;
  logic [31:0] out, s_out;

  int n_compared;
  int n_mismatched;

  systolic_pe #(.DATA_W(8), .ACC_W(32), .SIGNED(1'b0)) dut_u (
    .clk(clk), .rstn(rst), .fire(fire), .w(w), .a(a),
    .out_f(out_f), .out_a(out_a), .out_w(out_w), .out(out)
  );

  systolic_pe #(.DATA_W(8), .ACC_W(32), .SIGNED(1'b1)) dut_s (
    .clk(clk), .rstn(rst), .fire(s_fire), .w(s_w), .a(s_a),
    .out_f(s_out_f), .out_a(s_out_a), .out_w(s_out_w), .out(s_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; fire = 1'b1; w = 8'd5; a = 8'd7;
    s_fire = 1'b1; s_w = 8'd5; s_a = 8'd7;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_compared++;
      if (out !== 32'd0) begin n_mismatched++; $display("[TB] FAIL reset_out[%0d]: got %0d expected 0", i, out); end
      n_compared++;
      if (out_f !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_out_f[%0d]: got %0d expected 0", i, out_f); end
      n_compared++;
      if (out_a !== 8'd0) begin n_mismatched++; $display("[TB] FAIL reset_out_a[%0d]: got %0d expected 0", i, out_a); end
      n_compared++;
      if (out_w !== 8'd0) begin n_mismatched++; $display("[TB] FAIL reset_out_w[%0d]: got %0d expected 0", i, out_w); end
      n_compared++;
      if (s_out !== 32'd0) begin n_mismatched++; $display("[TB] FAIL reset_s_out[%0d]: got %0d expected 0", i, s_out); end
    end
    rst = 1'b0; s_fire = 1'b0;
  endtask

  task automatic test_basic_burst();
    logic [7:0]  tw [3]   = '{8'd2, 8'd4, 8'd1};
    logic [7:0]  ta [3]   = '{8'd3, 8'd5, 8'd10};
    logic [31:0] texp [3] = '{32'd6, 32'd26, 32'd36};
    for (int i = 0; i < 3; i++) begin
      fire = 1'b1; w = tw[i]; a = ta[i];
      tick();
      n_compared++;
      if (out !== texp[i]) begin n_mismatched++; $display("[TB] FAIL burst_out[%0d]: got %0d expected %0d", i, out, texp[i]); end
      n_compared++;
      if (out_w !== tw[i]) begin n_mismatched++; $display("[TB] FAIL burst_out_w[%0d]: got %0d expected %0d", i, out_w, tw[i]); end
      n_compared++;
      if (out_a !== ta[i]) begin n_mismatched++; $display("[TB] FAIL burst_out_a[%0d]: got %0d expected %0d", i, out_a, ta[i]); end
      n_compared++;
      if (out_f !== 1'b1) begin n_mismatched++; $display("[TB] FAIL burst_out_f[%0d]: got %0d expected 1", i, out_f); end
    end
  endtask

  task automatic test_hold_restart();
    for (int i = 0; i < 2; i++) begin
      fire = 1'b0; w = 8'd99 + 8'(i); a = 8'd77;
      tick();
      n_compared++;
      if (out !== 32'd36) begin n_mismatched++; $display("[TB] FAIL hold_out[%0d]: got %0d expected 36", i, out); end
      n_compared++;
      if (out_f !== 1'b0) begin n_mismatched++; $display("[TB] FAIL hold_out_f[%0d]: got %0d expected 0", i, out_f); end
      n_compared++;
      if (out_w !== 8'd99 + 8'(i)) begin n_mismatched++; $display("[TB] FAIL hold_out_w[%0d]: got %0d expected %0d", i, out_w, 8'd99 + 8'(i)); end
    end
    fire = 1'b1; w = 8'd3; a = 8'd3;
    tick();
    n_compared++;
    if (out !== 32'd9) begin n_mismatched++; $display("[TB] FAIL restart_out: got %0d expected 9", out); end
    fire = 1'b0;
    tick();
  endtask

  task automatic test_stream();
    logic [31:0] expected = 32'd0;
    for (int i = 0; i < 16; i++) begin
      fire = 1'b1; w = 8'(i); a = 8'(i + 1);
      expected = expected + 32'(i * (i + 1));
      tick();
      n_compared++;
      if (out !== expected) begin n_mismatched++; $display("[TB] FAIL stream_out[%0d]: got %0d expected %0d", i, out, expected); end
    end
    n_compared++;
    if (out !== 32'd1360) begin n_mismatched++; $display("[TB] FAIL stream_final: got %0d expected 1360", out); end
    fire = 1'b0;
    tick();
  endtask

  task automatic test_wrap_unsigned();
    logic [31:0] texp [3] = '{32'd65025, 32'd130050, 32'd195075};
    for (int i = 0; i < 3; i++) begin
      fire = 1'b1; w = 8'hFF; a = 8'hFF;
      tick();
      n_compared++;
      if (out !== texp[i]) begin n_mismatched++; $display("[TB] FAIL unsigned_out[%0d]: got %0d expected %0d", i, out, texp[i]); end
    end
    fire = 1'b0;
    tick();
  endtask

  task automatic test_signed();
    s_fire = 1'b1; s_w = 8'hFF; s_a = 8'h02;
    tick();
    n_compared++;
    if (s_out !== 32'hFFFF_FFFE) begin n_mismatched++; $display("[TB] FAIL signed_neg: got %h expected fffffffe", s_out); end
    s_w = 8'h03; s_a = 8'h04;
    tick();
    n_compared++;
    if (s_out !== 32'd10) begin n_mismatched++; $display("[TB] FAIL signed_acc: got %h expected 0000000a", s_out); end
    s_fire = 1'b0;
    tick();
    n_compared++;
    if (s_out !== 32'd10) begin n_mismatched++; $display("[TB] FAIL signed_hold: got %h expected 0000000a", s_out); end
  endtask

  task automatic test_reset_mid_burst();
    logic [31:0] texp [2] = '{32'd6, 32'd12};
    for (int i = 0; i < 2; i++) begin
      fire = 1'b1; w = 8'd2; a = 8'd3;
      tick();
      n_compared++;
      if (out !== texp[i]) begin n_mismatched++; $display("[TB] FAIL midrst_acc[%0d]: got %0d expected %0d", i, out, texp[i]); end
    end
    rst = 1'b1;
    tick();
    n_compared++;
    if (out !== 32'd0) begin n_mismatched++; $display("[TB] FAIL midrst_out: got %0d expected 0", out); end
    n_compared++;
    if (out_f !== 1'b0) begin n_mismatched++; $display("[TB] FAIL midrst_out_f: got %0d expected 0", out_f); end
    rst = 1'b0; w = 8'd1; a = 8'd1;
    tick();
    n_compared++;
    if (out !== 32'd1) begin n_mismatched++; $display("[TB] FAIL midrst_restart: got %0d expected 1", out); end
    fire = 1'b0;
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    rst = 1'b1; fire = 1'b0; w = '0; a = '0;
    s_fire = 1'b0; s_w = '0; s_a = '0;
    #1;
    test_reset();
    test_basic_burst();
    test_hold_restart();
    test_stream();
    test_wrap_unsigned();
    test_signed();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule : tb_systolic_pe

// File: doc/systolic_pe.md
Name: systolic_pe

Overview:
- Output-stationary multiply-accumulate processing element for a 2-D systolic array.
- Each cycle with fire asserted, multiplies incoming weight w by activation a and accumulates the product into a local accumulator, presented on out.
- Forwards w, a and fire, registered, to the east/south neighbours so PEs chain with one cycle of skew per hop.

Parameters:
- DATA_W, 8, width of w/a operands and forwarded operands
- ACC_W, 32, accumulator/out width; must be >= 2*DATA_W
- SIGNED, 0, 0 = unsigned operands; 1 = two's-complement operands, product sign-extended to ACC_W

Ports:
- clk  input  1  rising-edge clock
- rstn  input  1  synchronous reset, active-high (asserted = 1), sampled on rising clk
- fire  input  1  operand-valid / accumulate enable
- w  input  DATA_W  weight operand
- a  input  DATA_W  activation operand
- out_f  output  1  fire registered one cycle (to neighbour)
- out_a  output  DATA_W  a registered one cycle (to neighbour)
- out_w  output  DATA_W  w registered one cycle (to neighbour)
- out  output  ACC_W  accumulator value

Behaviour:
- All state updates on rising clk; no combinational path from any input to any output.
- Reset (rstn=1 at edge): out=0, out_f=0, out_a=0, out_w=0; reset has priority over fire.
- Forwarding: out_a<=a, out_w<=w, out_f<=fire every non-reset cycle, unconditionally; latency exactly 1 cycle.
- Product p = w*a, 2*DATA_W bits, zero- or sign-extended to ACC_W per SIGNED.
- Accumulate, burst semantics, using out_f as "previous fire":
  - fire=1, out_f=0 (first cycle of burst): out <= p (accumulator restarts; prior result discarded).
  - fire=1, out_f=1: out <= out + p.
  - fire=0: out holds.
- Result of a product appears on out at the same edge that captures the operands (1-cycle latency).
- Overflow: addition wraps modulo 2^ACC_W; no saturation, no overflow flag.
- Reset mid-burst: accumulator and out_f cleared; the next fire cycle is treated as a burst start.
- X on w/a while fire=0 must not affect out; it may propagate to out_a/out_w.

Decomposition:
- Shared package systolic_pkg: DATA_W/ACC_W default constants, and an operand typedef and accumulator typedef sized from them, for use by array-level modules.
- One natural sub-module: pe_mac, the combinational multiplier with SIGNED-aware extension, returning the ACC_W-wide product. Registers, burst-start detection and forwarding stay in systolic_pe.

Test Plan:
- Reset: hold rstn=1 for 2 edges with fire=1, w=5, a=7 -> out=0, out_f=0, out_a=0, out_w=0 after each edge.
- Basic burst: release reset, fire=1, (w,a)=(2,3),(4,5),(1,10) on successive edges -> out=6, 26, 36; out_w/out_a each edge equal to previous-cycle inputs; out_f=1 one edge after fire.
- Hold and restart: after previous case drop fire for 2 edges -> out stays 36, out_f=0; re-assert fire with (3,3) -> out=9, not 45.
- 16-cycle stream: fire=1, w=i, a=i+1 for i=0..15 -> after cycle i, out = sum k*(k+1) for k=0..i; final out=1360.
- Wrap/signed: SIGNED=0, (255,255) x 3 -> out=65025, 130050, 195075. SIGNED=1: (0xFF,0x02) -> out=0xFFFFFFFE, i.e. -2; then (0x03,0x04) -> out=10.
- Reset mid-burst: accumulate (2,3),(2,3) to 12, assert rstn one edge with fire=1 -> out=0; release with (1,1) -> out=1.
